// File: rtl/snic_axis_pkg.sv
// Shared AXI-Stream widths, arbiter state type and the round-robin pick helper
// used by the snic TX packet arbiter.
package snic_axis_pkg;

   localparam int unsigned SNIC_AXIS_DATA_W = 512;
   localparam int unsigned SNIC_AXIS_KEEP_W = 64;
   localparam int unsigned RR_MAX_PORTS     = 32;

   typedef enum logic {IDLE, BUSY} arb_state_t;

   // First requester after 'last' in circular order; returns 'last' when nobody requests.
   function automatic int unsigned rr_pick(input logic [RR_MAX_PORTS-1:0] req,
                                           input int unsigned last,
                                           input int unsigned num);
      int unsigned idx;
      int unsigned pick;
      logic        found;
      pick  = last;
      found = 1'b0;
      for (int unsigned i = 1; i <= RR_MAX_PORTS; i++) begin
         idx = last + i;
         if (idx >= num) idx = idx - num;
         if (i <= num && !found && req[idx[4:0]]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/snic_axis_reg_slice.sv
// One-entry AXI-Stream output register: accepts a beat whenever it is empty or
// being drained, and holds its payload stable while stalled.
module snic_axis_reg_slice #(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned KEEP_WIDTH = 64,
   parameter int unsigned DEST_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [KEEP_WIDTH-1:0] in_keep,
   input  logic                  in_last,
   input  logic [DEST_WIDTH-1:0] in_dest,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [KEEP_WIDTH-1:0] out_keep,
   output logic                  out_last,
   output logic [DEST_WIDTH-1:0] out_dest,
   output logic                  out_valid,
   input  logic                  out_ready
);

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
         out_dest  <= '0;
         out_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
         out_data  <= in_data;
         out_keep  <= in_keep;
         out_last  <= in_last;
         out_dest  <= in_dest;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/snic_tx_pkt_arbiter.sv
// Packet-atomic round-robin merge of NUM_PORTS TX AXI-Stream sources onto one
// net TX port; each output beat carries its source index on tdest.
module snic_tx_pkt_arbiter
   import snic_axis_pkg::*;
#(
   parameter int unsigned NUM_PORTS  = 2,
   parameter int unsigned DATA_WIDTH = SNIC_AXIS_DATA_W,
   parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned DEST_WIDTH = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                            clk_250mhz,
   input  logic                            clk_250mhz_rst,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic [NUM_PORTS-1:0]            s_axis_tlast,
   input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
   output logic [NUM_PORTS-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]           m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
   output logic                            m_axis_tlast,
   output logic [DEST_WIDTH-1:0]           m_axis_tdest,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [NUM_PORTS*CNT_WIDTH-1:0]  pkt_cnt
);

   arb_state_t                  state, state_next;
   logic [DEST_WIDTH-1:0]       grant, grant_next;
   logic [DEST_WIDTH-1:0]       last_grant, last_grant_next;
   logic [DATA_WIDTH-1:0]       in_data;
   logic [KEEP_WIDTH-1:0]       in_keep;
   logic                        in_last;
   logic                        in_valid;
   logic                        in_ready;
   logic                        cnt_inc;
   logic [NUM_PORTS*CNT_WIDTH-1:0] cnt;

   always_comb begin
      state_next      = state;
      grant_next      = grant;
      last_grant_next = last_grant;
      s_axis_tready   = '0;
      in_valid        = 1'b0;
      cnt_inc         = 1'b0;
      in_data         = s_axis_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
      in_keep         = s_axis_tkeep[grant*KEEP_WIDTH +: KEEP_WIDTH];
      in_last         = s_axis_tlast[grant];
      case (state)
         IDLE: begin
            if (|s_axis_tvalid) begin
               grant_next = DEST_WIDTH'(rr_pick(RR_MAX_PORTS'(s_axis_tvalid),
                                                32'(last_grant), NUM_PORTS));
               state_next = BUSY;
            end
         end
         BUSY: begin
            // Held low during reset so a source never sees a beat taken that the flush discards.
            s_axis_tready[grant] = in_ready && !clk_250mhz_rst;
            in_valid             = s_axis_tvalid[grant];
            if (in_valid && in_ready && in_last) begin
               cnt_inc         = 1'b1;
               last_grant_next = grant;
               state_next      = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_250mhz) begin
      if (clk_250mhz_rst) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= DEST_WIDTH'(NUM_PORTS - 1);
         cnt        <= '0;
      end else begin
         state      <= state_next;
         grant      <= grant_next;
         last_grant <= last_grant_next;
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (cnt_inc && grant == DEST_WIDTH'(i))
               cnt[i*CNT_WIDTH +: CNT_WIDTH] <= cnt[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
         end
      end
   end

   assign pkt_cnt = cnt;

   snic_axis_reg_slice #(
      .DATA_WIDTH (DATA_WIDTH),
      .KEEP_WIDTH (KEEP_WIDTH),
      .DEST_WIDTH (DEST_WIDTH)
   ) u_out_slice (
      .clk       (clk_250mhz),
      .rst       (clk_250mhz_rst),
      .in_data   (in_data),
      .in_keep   (in_keep),
      .in_last   (in_last),
      .in_dest   (grant),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (m_axis_tdata),
      .out_keep  (m_axis_tkeep),
      .out_last  (m_axis_tlast),
      .out_dest  (m_axis_tdest),
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready)
   );

endmodule

// File: tb/tb_snic_tx_pkt_arbiter.sv
// Directed per-cycle vector bench for the snic TX packet arbiter (two ports);
// each step drives one cycle of inputs and checks that cycle's outputs.
module tb_snic_tx_pkt_arbiter;

   localparam int NP = 2;
   localparam int DW = 512;
   localparam int KW = 64;
   localparam int CW = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [NP*DW-1:0] s_tdata;
   logic [NP*KW-1:0] s_tkeep;
   logic [NP-1:0]    s_tlast;
   logic [NP-1:0]    s_tvalid;
   logic [NP-1:0]    s_tready;
   logic [DW-1:0]    m_tdata;
   logic [KW-1:0]    m_tkeep;
   logic             m_tlast;
   logic [0:0]       m_tdest;
   logic             m_tvalid;
   logic             m_tready;
   logic [NP*CW-1:0] pkt_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   snic_tx_pkt_arbiter #(
      .NUM_PORTS  (NP),
      .DATA_WIDTH (DW),
      .KEEP_WIDTH (KW),
      .DEST_WIDTH (1),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk_250mhz     (clk),
      .clk_250mhz_rst (rst),
      .s_axis_tdata   (s_tdata),
      .s_axis_tkeep   (s_tkeep),
      .s_axis_tlast   (s_tlast),
      .s_axis_tvalid  (s_tvalid),
      .s_axis_tready  (s_tready),
      .m_axis_tdata   (m_tdata),
      .m_axis_tkeep   (m_tkeep),
      .m_axis_tlast   (m_tlast),
      .m_axis_tdest   (m_tdest),
      .m_axis_tvalid  (m_tvalid),
      .m_axis_tready  (m_tready),
      .pkt_cnt        (pkt_cnt)
   );

   // Per-port data is the 8-bit tag replicated; keep is the tag replicated, so tag 00 is a keep=0 beat.
   typedef struct {
      logic       rst;
      logic [1:0] v;
      logic [1:0] l;
      logic [7:0] t0;
      logic [7:0] t1;
      logic       mr;
      logic [1:0] e_rdy;
      logic       e_mv;
      logic       ck;
      logic [7:0] e_tag;
      logic       e_last;
      logic       e_dest;
      int         e_c0;
      int         e_c1;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [1:0] l,
                               input logic [7:0] t0, input logic [7:0] t1, input logic mr,
                               input logic [1:0] er, input logic emv, input logic ck,
                               input logic [7:0] et, input logic el, input logic ed,
                               input int c0, input int c1);
      vec_t x;
      x.rst = r;  x.v = v;  x.l = l;  x.t0 = t0;  x.t1 = t1;  x.mr = mr;
      x.e_rdy = er;  x.e_mv = emv;  x.ck = ck;  x.e_tag = et;
      x.e_last = el;  x.e_dest = ed;  x.e_c0 = c0;  x.e_c1 = c1;
      return x;
   endfunction

   function automatic logic [7:0] tg(input int i, input int j, input int b);
      return 8'(8'h40 * (i + 1) + 4 * j + b);
   endfunction

   task automatic chk(input string nm, input int id, input logic [DW-1:0] got,
                      input logic [DW-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s step %0d: got %0h want %0h", nm, id, got, want);
      end
   endtask

   task automatic step(input vec_t r, input int id);
      @(negedge clk);
      rst      = r.rst;
      s_tvalid = r.v;
      s_tlast  = r.l;
      s_tdata  = {{64{r.t1}}, {64{r.t0}}};
      s_tkeep  = {{8{r.t1}}, {8{r.t0}}};
      m_tready = r.mr;
      #1;
      chk("tready", id, DW'(s_tready), DW'(r.e_rdy));
      chk("m_tvalid", id, DW'(m_tvalid), DW'(r.e_mv));
      if (r.ck) begin
         chk("m_tdata", id, m_tdata, {64{r.e_tag}});
         chk("m_tkeep", id, DW'(m_tkeep), DW'({8{r.e_tag}}));
         chk("m_tlast", id, DW'(m_tlast), DW'(r.e_last));
         chk("m_tdest", id, DW'(m_tdest), DW'(r.e_dest));
      end
      chk("pkt_cnt0", id, DW'(pkt_cnt[CW-1:0]), DW'(r.e_c0));
      chk("pkt_cnt1", id, DW'(pkt_cnt[2*CW-1:CW]), DW'(r.e_c1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] rb;
      logic [7:0] tp0, tp1, tq, a0, a1, a2, prev;
      int p, q, jp, jq, c0, c1, pp, pj;

      // Idle after reset, payload cleared.
      tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 1, 8'h00, 0, 0, 0, 0));
      // Port0 3-beat packet, continuous downstream accept.
      tbl.push_back(mk(0, 2'b01, 2'b00, 8'hA0, 8'h00, 1, 2'b00, 0, 0, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2'b01, 2'b00, 8'hA0, 8'h00, 1, 2'b01, 0, 0, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2'b01, 2'b00, 8'hA1, 8'h00, 1, 2'b01, 1, 1, 8'hA0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2'b01, 2'b01, 8'hA2, 8'h00, 1, 2'b01, 1, 1, 8'hA1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 1, 1, 8'hA2, 1, 0, 1, 0));
      tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0, 8'h00, 0, 0, 1, 0));
      tbl.push_back(mk(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0, 8'h00, 0, 0, 1, 0));
      // Port1 4-beat packet (third beat keep=0) with downstream ready toggling.
      tbl.push_back(mk(0, 2'b10, 2'b00, 8'h00, 8'hB0, 1, 2'b00, 0, 1, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2'b10, 2'b00, 8'h00, 8'hB0, 1, 2'b10, 0, 0, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2'b10, 2'b00, 8'h00, 8'hB1, 0, 2'b00, 1, 1, 8'hB0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 2'b10, 2'b00, 8'h00, 8'hB1, 1, 2'b10, 1, 1, 8'hB0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 2'b10, 2'b00, 8'h00, 8'h00, 0, 2'b00, 1, 1, 8'hB1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 2'b10, 2'b00, 8'h00, 8'h00, 1, 2'b10, 1, 1, 8'hB1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 2'b10, 2'b10, 8'h00, 8'hB3, 0, 2'b00, 1, 1, 8'h00, 0, 1, 0, 0));
      tbl.push_back(mk(0, 2'b10, 2'b10, 8'h00, 8'hB3, 1, 2'b10, 1, 1, 8'h00, 0, 1, 0, 0));
      tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 2'b00, 1, 1, 8'hB3, 1, 1, 0, 1));
      tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 1, 1, 8'hB3, 1, 1, 0, 1));
      tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0, 8'h00, 0, 0, 0, 1));
      // Port0 stalls 5 cycles mid-packet; port1 (single-beat) waits, grant wraps 1->0->1.
      tbl.push_back(mk(0, 2'b11, 2'b10, 8'hC0, 8'hE0, 1, 2'b00, 0, 0, 8'h00, 0, 0, 0, 1));
      tbl.push_back(mk(0, 2'b11, 2'b10, 8'hC0, 8'hE0, 1, 2'b01, 0, 0, 8'h00, 0, 0, 0, 1));
      tbl.push_back(mk(0, 2'b10, 2'b10, 8'hC1, 8'hE0, 1, 2'b01, 1, 1, 8'hC0, 0, 0, 0, 1));
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(0, 2'b10, 2'b10, 8'hC1, 8'hE0, 1, 2'b01, 0, 0, 8'h00, 0, 0, 0, 1));
      tbl.push_back(mk(0, 2'b11, 2'b10, 8'hC1, 8'hE0, 1, 2'b01, 0, 0, 8'h00, 0, 0, 0, 1));
      tbl.push_back(mk(0, 2'b11, 2'b11, 8'hC2, 8'hE0, 1, 2'b01, 1, 1, 8'hC1, 0, 0, 0, 1));
      tbl.push_back(mk(0, 2'b10, 2'b10, 8'h00, 8'hE0, 1, 2'b00, 1, 1, 8'hC2, 1, 0, 1, 1));
      tbl.push_back(mk(0, 2'b10, 2'b10, 8'h00, 8'hE0, 1, 2'b10, 0, 0, 8'h00, 0, 0, 1, 1));
      tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 1, 1, 8'hE0, 1, 1, 1, 2));
      tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0, 8'h00, 0, 0, 1, 2));
      // Reset after two beats of a 4-beat packet; port0 restarts with a single-beat packet.
      tbl.push_back(mk(0, 2'b01, 2'b00, 8'hF0, 8'h00, 1, 2'b00, 0, 0, 8'h00, 0, 0, 1, 2));
      tbl.push_back(mk(0, 2'b01, 2'b00, 8'hF0, 8'h00, 1, 2'b01, 0, 0, 8'h00, 0, 0, 1, 2));
      tbl.push_back(mk(0, 2'b01, 2'b00, 8'hF1, 8'h00, 1, 2'b01, 1, 1, 8'hF0, 0, 0, 1, 2));
      tbl.push_back(mk(1, 2'b01, 2'b00, 8'hF2, 8'h00, 1, 2'b00, 1, 1, 8'hF1, 0, 0, 1, 2));
      tbl.push_back(mk(0, 2'b01, 2'b00, 8'h60, 8'h00, 1, 2'b00, 0, 1, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2'b01, 2'b01, 8'h60, 8'h00, 1, 2'b01, 0, 0, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 1, 1, 8'h60, 1, 0, 1, 0));
      tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0, 8'h00, 0, 0, 1, 0));

      rst      = 1'b1;
      s_tvalid = '0;
      s_tlast  = '0;
      s_tdata  = '0;
      s_tkeep  = '0;
      m_tready = 1'b0;
      repeat (25) @(posedge clk);

      foreach (tbl[i]) step(tbl[i], i);

      // Both ports always requesting 2-beat packets: strict 0,1,0,1 rotation, 3 cycles per packet.
      step(mk(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0, 8'h00, 0, 0, 1, 0), 100);
      for (int n = 0; n < 8; n++) begin
         p   = n % 2;
         q   = 1 - p;
         c0  = (n + 1) / 2;
         c1  = n / 2;
         jp  = (p == 0) ? c0 : c1;
         jq  = (q == 0) ? c0 : c1;
         tp0 = tg(p, jp, 0);
         tp1 = tg(p, jp, 1);
         tq  = tg(q, jq, 0);
         rb  = (p == 0) ? 2'b01 : 2'b10;
         pp  = (n + 1) % 2;
         pj  = (n > 0) ? (n - 1) / 2 : 0;
         prev = tg(pp, pj, 1);
         a0  = (p == 0) ? tp0 : tq;
         a1  = (p == 0) ? tq : tp0;
         step(mk(0, 2'b11, 2'b00, a0, a1, 1, 2'b00, n > 0, n > 0, prev, 1, pp[0], c0, c1),
              110 + 3 * n);
         step(mk(0, 2'b11, 2'b00, a0, a1, 1, rb, 0, 0, 8'h00, 0, 0, c0, c1), 111 + 3 * n);
         a2 = (p == 0) ? tp1 : tq;
         a1 = (p == 0) ? tq : tp1;
         step(mk(0, 2'b11, rb, a2, a1, 1, rb, 1, 1, tp0, 0, p[0], c0, c1), 112 + 3 * n);
      end
      step(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 1, 1, tg(1, 3, 1), 1, 1, 4, 4), 140);
      step(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0, 8'h00, 0, 0, 4, 4), 141);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
